sample_rle_stream: RTL and testbench
====================================

Name: sample_rle_stream

Overview:
- Parametrised next-generation run-length compressor for the logic-analyser capture path. It sits between the sample strober/serializer output and the USB/DMA packetiser.
- Generalised in data width, run-counter width, page size and sample-index width.
- Adds real valid/ready backpressure on both sides through an internal output FIFO, so there is no "strobe must be followed by an idle cycle" rule and no overflow error.
- Adds an explicit end-of-capture flush and tags every output word as literal or run count.

Parameters:
- W, 16, sample/data width in bits.
- CNT_W, 16, run-counter width; count words are zero-extended to W (CNT_W <= W).
- PAGE_LOG2, 15, a page is 2^PAGE_LOG2 output words.
- IDX_W, 40, sample-index width.
- DEPTH, 4, output FIFO depth (power of two, >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- clear  in  1  synchronous restart: empties FIFO, zeroes index and page counter, state to INIT
- flush  in  1  pulse: emit any pending run count (end of capture)
- in_data  in  W  sample
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- out_data  out  W  literal sample or zero-extended run count
- out_is_count  out  1  1 = out_data is a run count
- out_new_page  out  1  first word of a page
- out_index  out  IDX_W  sample index for the word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops when out_valid && out_ready
- busy  out  1  FIFO non-empty or state != INIT/SINGLE

Behaviour:
- Reset values: in_ready=0 during reset, then 1. out_valid=0. out_data, out_is_count, out_new_page, out_index = 0. busy=0. Internal index=0, page counter=0, page_start latch=1.
- Accept condition: a sample is accepted when in_valid && in_ready.
- in_ready is 1 when all of the following hold: FIFO free slots >= 2, state != PENDING, no clear, no flush this cycle.
- State INIT: accepted sample → push literal with out_index=idx; go to SINGLE.
- State SINGLE: accepted sample differs from last → push literal, stay in SINGLE. Equal → push nothing; cnt=1; run_idx=idx; go to RUN.
- State RUN, equal sample:
  - cnt+1 < 2^CNT_W-1 → increment, no push.
  - cnt+1 == 2^CNT_W-1 → push count word (all-ones) with out_index=run_idx; set cnt=0 and go to RUN0.
- State RUN, differing sample: push count=cnt with out_index=run_idx; hold the sample and its idx; go to PENDING.
- State PENDING: no input accepted. Push the held literal next cycle; go to SINGLE.
- State RUN0 (saturated, nothing pending):
  - equal sample → cnt=1, run_idx=idx, go to RUN.
  - differing sample → push literal, go to SINGLE.
- Count semantics: a count word value n means "n further copies of the preceding literal".
- Index: idx increments by 1 per accepted sample and wraps modulo 2^IDX_W.
- Paging:
  - The page counter increments per pushed word.
  - Push with counter == 2^PAGE_LOG2-1 ends the page; the counter wraps to 0.
  - After a page end, the state goes to INIT once any PENDING literal has been pushed, so the next accepted sample is always a literal.
  - A PENDING literal is pushed as the first word of the new page.
  - out_new_page=1 on the first pushed word after reset, clear, or page end.
- Flush:
  - In RUN → push count=cnt; go to INIT.
  - In SINGLE or RUN0 → go to INIT.
  - In PENDING → push the literal this cycle, then go to INIT.
  - In INIT → no effect.
  - Flush takes priority over in_valid in the same cycle.
- Clear: highest priority, including over flush. Drops FIFO contents and any pending word.
- FIFO: registered head outputs. Push and pop may occur in the same cycle. Never pushes when full, guaranteed by the in_ready rule. Latency from accepted literal to out_valid is 1 cycle when the FIFO is empty.
- Reset mid-run: all state is lost; there is no partial emission.

Test Plan:
- Defaults; inputs 0x0001, 0x0002, 0x0003 back-to-back, out_ready=1 → three literals, idx 0,1,2; first word has out_new_page=1; in_ready stays 1.
- Inputs 0xAAAA x5 then 0x5555 → literal AAAA(idx0), count 4(idx1), literal 5555(idx5). in_ready=0 for exactly one cycle after 0x5555.
- CNT_W=4; 0x0007 x20 then flush → literal(idx0), count 15(idx1), count 4(idx16). busy drops after the FIFO drains.
- PAGE_LOG2=2; 6 distinct values → words 0 and 4 carry out_new_page=1. Then 0x0009 repeated at a page boundary → a literal is re-emitted, not counted.
- out_ready=0 with continuous distinct input → in_ready falls once FIFO free < 2, no words are lost. Release out_ready → order is preserved.
- clear asserted in RUN with FIFO non-empty → out_valid=0 next cycle. The next sample is a literal with idx 0 and out_new_page=1.

Source files
------------

// File: rtl/sample_rle_stream_if.sv
// sample_rle_stream_if
// Sample-in / word-out bundle of the run-length compressor.
//   in_data/in_valid/in_ready          : sample stream towards the compressor
//   out_data/out_is_count/out_new_page : head word of the output FIFO
//   out_index/out_valid/out_ready      : sample index of the head word and handshake
// Modports:
//   slave  : the compressor's view (consumes samples, produces words)
//   master : the producer/consumer view around it
interface sample_rle_stream_if #(
  parameter int W     = 16,
  parameter int IDX_W = 40
);
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_data;
  logic             out_is_count;
  logic             out_new_page;
  logic [IDX_W-1:0] out_index;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_is_count, out_new_page, out_index, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_is_count, out_new_page, out_index, out_valid
  );
endinterface

// File: rtl/sample_rle_stream.sv
// sample_rle_stream
// Run-length compressor for the logic-analyser capture path. Each accepted
// sample is either emitted as a literal or folded into a run count that
// means "n further copies of the preceding literal". Output words are tagged
// literal/count, carry the sample index they refer to, and mark the first
// word of every 2^PAGE_LOG2-word page. A small output FIFO provides real
// backpressure towards the packetiser.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous restart (empties FIFO, zeroes index and page counter)
//   flush  : end-of-capture pulse, emits any pending run count
//   busy   : FIFO non-empty or a run/pending literal is in flight
//   bus    : sample input and word output streams (slave modport)
module sample_rle_stream #(
  parameter int W         = 16,
  parameter int CNT_W     = 16,
  parameter int PAGE_LOG2 = 15,
  parameter int IDX_W     = 40,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               flush,
  output logic               busy,
  sample_rle_stream_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = 2 + IDX_W + W;

  // Value of the counter one below saturation (2^CNT_W - 2).
  localparam logic [CNT_W-1:0] CNT_PRE_SAT = ~CNT_W'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_SINGLE,
    S_RUN,
    S_RUN0,
    S_PENDING
  } state_t;

  // Compressor state
  state_t               state_reg;
  logic [W-1:0]         last_reg;
  logic [W-1:0]         held_data_reg;
  logic [IDX_W-1:0]     held_idx_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [IDX_W-1:0]     run_idx_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [PAGE_LOG2-1:0] page_cnt_reg;
  logic                 page_start_reg;
  logic                 rst_done_reg;

  // Output FIFO: a registered head word plus a small body store behind it
  logic [ENT_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [OCC_W-1:0]     body_cnt_reg;
  logic                 head_valid_reg;
  logic [ENT_W-1:0]     head_reg;

  logic [OCC_W-1:0]     occupancy;
  logic                 in_ready_int;
  logic                 accept;
  logic                 same;
  logic                 cnt_sat;

  logic                 push_en;
  logic                 push_is_count;
  logic [W-1:0]         push_data;
  logic [IDX_W-1:0]     push_idx;
  logic [ENT_W-1:0]     push_word;
  logic                 page_end;

  logic                 pop;
  logic                 head_load;
  logic                 body_wr;
  logic                 body_rd;

  assign occupancy = body_cnt_reg + OCC_W'(head_valid_reg);

  // Two free slots are required because a run broken by a new value pushes
  // the count now and the held literal on the following cycle.
  // rst_done_reg keeps the input closed until the first edge after reset.
  assign in_ready_int = rst_done_reg && !clear && !flush &&
                        (state_reg != S_PENDING) &&
                        (occupancy <= OCC_W'(DEPTH - 2));

  assign accept  = bus.in_valid && in_ready_int;
  assign same    = (bus.in_data == last_reg);
  assign cnt_sat = (cnt_reg == CNT_PRE_SAT);

  // Word produced this cycle (at most one per cycle)
  always_comb begin
    push_en       = 1'b0;
    push_is_count = 1'b0;
    push_data     = '0;
    push_idx      = '0;
    if (!clear) begin
      case (state_reg)
        S_INIT: begin
          if (accept) begin
            push_en   = 1'b1;
            push_data = bus.in_data;
            push_idx  = idx_reg;
          end
        end
        S_SINGLE, S_RUN0: begin
          if (accept && !same) begin
            push_en   = 1'b1;
            push_data = bus.in_data;
            push_idx  = idx_reg;
          end
        end
        S_RUN: begin
          if (flush || (accept && !same)) begin
            push_en                 = 1'b1;
            push_is_count           = 1'b1;
            push_data[CNT_W-1:0]    = cnt_reg;
            push_idx                = run_idx_reg;
          end else if (accept && cnt_sat) begin
            push_en                 = 1'b1;
            push_is_count           = 1'b1;
            push_data[CNT_W-1:0]    = '1;
            push_idx                = run_idx_reg;
          end
        end
        S_PENDING: begin
          // The held literal goes out whether or not flush is asserted.
          push_en   = 1'b1;
          push_data = held_data_reg;
          push_idx  = held_idx_reg;
        end
        default: ;
      endcase
    end
  end

  assign page_end  = push_en && (page_cnt_reg == '1);
  assign push_word = {push_is_count, page_start_reg, push_idx, push_data};

  // Compressor FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_INIT;
      last_reg       <= '0;
      held_data_reg  <= '0;
      held_idx_reg   <= '0;
      idx_reg        <= '0;
      run_idx_reg    <= '0;
      cnt_reg        <= '0;
      page_cnt_reg   <= '0;
      page_start_reg <= 1'b1;
      rst_done_reg   <= 1'b0;
    end else begin
      rst_done_reg <= 1'b1;
      if (clear) begin
        state_reg      <= S_INIT;
        idx_reg        <= '0;
        cnt_reg        <= '0;
        page_cnt_reg   <= '0;
        page_start_reg <= 1'b1;
      end else begin
        if (push_en) begin
          page_cnt_reg   <= page_cnt_reg + PAGE_LOG2'(1);
          page_start_reg <= page_end;
        end
        if (accept) begin
          idx_reg  <= idx_reg + IDX_W'(1);
          last_reg <= bus.in_data;
        end
        if (flush) begin
          // RUN pushed its count and PENDING its literal above.
          state_reg <= S_INIT;
        end else begin
          case (state_reg)
            S_INIT: begin
              if (accept)
                state_reg <= page_end ? S_INIT : S_SINGLE;
            end
            S_SINGLE, S_RUN0: begin
              if (accept) begin
                if (same) begin
                  cnt_reg     <= CNT_W'(1);
                  run_idx_reg <= idx_reg;
                  state_reg   <= S_RUN;
                end else begin
                  state_reg   <= page_end ? S_INIT : S_SINGLE;
                end
              end
            end
            S_RUN: begin
              if (accept) begin
                if (!same) begin
                  held_data_reg <= bus.in_data;
                  held_idx_reg  <= idx_reg;
                  state_reg     <= S_PENDING;
                end else if (cnt_sat) begin
                  cnt_reg   <= '0;
                  state_reg <= page_end ? S_INIT : S_RUN0;
                end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                end
              end
            end
            S_PENDING: begin
              // page_start_reg set here means the count just closed a page and
              // this literal opened the next one; restart from INIT so the
              // next sample is never counted against a previous page.
              state_reg <= (page_start_reg || page_end) ? S_INIT : S_SINGLE;
            end
            default: state_reg <= S_INIT;
          endcase
        end
      end
    end
  end

  // Output FIFO
  assign pop       = head_valid_reg && bus.out_ready;
  assign head_load = !head_valid_reg || pop;
  assign body_rd   = head_load && (body_cnt_reg != '0);
  // A push bypasses the body only when the head is being refilled from empty.
  assign body_wr   = push_en && !(head_load && (body_cnt_reg == '0));

  always_ff @(posedge clk) begin
    if (body_wr)
      mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_reg <= 1'b0;
      head_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      body_cnt_reg   <= '0;
    end else if (clear) begin
      head_valid_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      body_cnt_reg   <= '0;
    end else begin
      if (head_load) begin
        if (body_rd) begin
          head_reg       <= mem[rd_ptr_reg];
          head_valid_reg <= 1'b1;
        end else if (push_en) begin
          head_reg       <= push_word;
          head_valid_reg <= 1'b1;
        end else begin
          head_valid_reg <= 1'b0;
        end
      end
      if (body_rd)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (body_wr)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      case ({body_wr, body_rd})
        2'b10:   body_cnt_reg <= body_cnt_reg + OCC_W'(1);
        2'b01:   body_cnt_reg <= body_cnt_reg - OCC_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.out_valid = head_valid_reg;
  assign {bus.out_is_count, bus.out_new_page, bus.out_index, bus.out_data} = head_reg;

  assign busy = head_valid_reg || (body_cnt_reg != '0) ||
                (state_reg == S_RUN) || (state_reg == S_RUN0) ||
                (state_reg == S_PENDING);

endmodule

// File: tb/tb_sample_rle_stream.sv
// tb_sample_rle_stream
// Directed scenarios followed by randomized traffic; every popped word is
// compared with a reference model that compresses the accepted sample
// stream at the level of "reference literal + run length + page position".
module tb_sample_rle_stream;

  localparam int W         = 16;
  localparam int CNT_W     = 4;
  localparam int PAGE_LOG2 = 2;
  localparam int IDX_W     = 40;
  localparam int DEPTH     = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int PAGE      = 1 << PAGE_LOG2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic flush = 1'b0;
  logic busy;

  sample_rle_stream_if #(.W(W), .IDX_W(IDX_W)) bus ();

  sample_rle_stream #(
    .W(W), .CNT_W(CNT_W), .PAGE_LOG2(PAGE_LOG2), .IDX_W(IDX_W), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     data;
    bit               is_count;
    bit               new_page;
    logic [IDX_W-1:0] idx;
  } word_t;

  word_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  bit    accepted;
  bit    last_in_ready;

  // Reference model state
  logic [IDX_W-1:0] m_idx;
  int               m_page_pos;
  bit               m_ref_valid;
  logic [W-1:0]     m_ref;
  int               m_run;
  logic [IDX_W-1:0] m_run_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_emit(input logic [W-1:0] d, input bit is_cnt, input logic [IDX_W-1:0] ix);
    word_t w;
    w.data     = d;
    w.is_count = is_cnt;
    w.new_page = (m_page_pos == 0);
    w.idx      = ix;
    exp_q.push_back(w);
    m_page_pos = (m_page_pos + 1) % PAGE;
    if (m_page_pos == 0) begin
      // A closed page forgets its reference literal.
      m_ref_valid = 1'b0;
      m_run       = 0;
    end
  endtask

  task automatic m_clear();
    exp_q.delete();
    m_idx       = '0;
    m_page_pos  = 0;
    m_ref_valid = 1'b0;
    m_ref       = '0;
    m_run       = 0;
    m_run_idx   = '0;
  endtask

  task automatic m_flush();
    if (m_run > 0) m_emit(W'(m_run), 1'b1, m_run_idx);
    m_run       = 0;
    m_ref_valid = 1'b0;
  endtask

  task automatic m_sample(input logic [W-1:0] v);
    bit page_broke;
    if (!m_ref_valid) begin
      m_ref       = v;
      m_ref_valid = 1'b1;
      m_emit(v, 1'b0, m_idx);
    end else if (v == m_ref) begin
      if (m_run == 0) m_run_idx = m_idx;
      m_run++;
      if (m_run == CMAX) begin
        m_emit(W'(CMAX), 1'b1, m_run_idx);
        m_run = 0;
      end
    end else begin
      page_broke = 1'b0;
      if (m_run > 0) begin
        m_emit(W'(m_run), 1'b1, m_run_idx);
        m_run      = 0;
        page_broke = !m_ref_valid;
      end
      m_ref       = v;
      m_ref_valid = 1'b1;
      m_emit(v, 1'b0, m_idx);
      if (page_broke) m_ref_valid = 1'b0;
    end
    m_idx = m_idx + IDX_W'(1);
  endtask

  // One clock cycle: drive at negedge, observe 1 time unit later.
  task automatic step(input bit v, input logic [W-1:0] d, input bit f, input bit c, input bit rdy);
    word_t w;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    flush         = f;
    clear         = c;
    bus.out_ready = rdy;
    #1;
    last_in_ready = bus.in_ready;
    accepted      = v && bus.in_ready;
    if (bus.out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(bus.out_valid), 64'd0);
      end else begin
        w = exp_q.pop_front();
        check("word_data",     64'(bus.out_data),     64'(w.data));
        check("word_is_count", 64'(bus.out_is_count), 64'(w.is_count));
        check("word_new_page", 64'(bus.out_new_page), 64'(w.new_page));
        check("word_index",    64'(bus.out_index),    64'(w.idx));
      end
    end
    if (c || f) check("ready_gated", 64'(last_in_ready), 64'd0);
    if (c)            m_clear();
    else if (f)       m_flush();
    else if (accepted) m_sample(d);
  endtask

  task automatic send(input logic [W-1:0] d, input bit rdy, output int tries);
    tries = 0;
    do begin
      step(1'b1, d, 1'b0, 1'b0, rdy);
      tries++;
    end while (!accepted && tries < 64);
    if (!accepted) check("send_timeout", 64'(last_in_ready), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.out_valid); k++)
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          tries;
    int          n;
    logic [W-1:0] v;
    logic [W-1:0] cur;
    bit          rc, rf;

    m_clear();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #2;
    check("rst_in_ready",     64'(bus.in_ready),     64'd0);
    check("rst_out_valid",    64'(bus.out_valid),    64'd0);
    check("rst_busy",         64'(busy),             64'd0);
    check("rst_out_data",     64'(bus.out_data),     64'd0);
    check("rst_out_index",    64'(bus.out_index),    64'd0);
    check("rst_out_is_count", 64'(bus.out_is_count), 64'd0);
    check("rst_out_new_page", 64'(bus.out_new_page), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("post_rst_ready", 64'(last_in_ready), 64'd1);

    // Three distinct literals back-to-back
    for (int i = 1; i <= 3; i++) begin
      send(W'(i), 1'b1, tries);
      check("b2b_first_try", 64'(tries), 64'd1);
    end
    drain();

    // Run of AAAA then 5555: in_ready low for exactly one cycle
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (5) send(16'hAAAA, 1'b1, tries);
    send(16'h5555, 1'b1, tries);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("pending_ready_low", 64'(last_in_ready), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("pending_ready_back", 64'(last_in_ready), 64'd1);
    drain();

    // Saturating run then flush
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (20) send(16'h0007, 1'b1, tries);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("busy_in_run", 64'(busy), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("busy_after_drain", 64'(busy), 64'd0);

    // Paging: six distinct values, then a repeat straddling a page end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send(16'h0010 + W'(i), 1'b1, tries);
    send(16'h0020, 1'b1, tries);
    send(16'h0009, 1'b1, tries);
    send(16'h0009, 1'b1, tries);
    drain();

    // Backpressure: out_ready low with continuous distinct input
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    n = 0;
    v = 16'h0100;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, v, 1'b0, 1'b0, 1'b0);
      if (accepted) begin
        n++;
        v = v + W'(1);
      end
    end
    check("stall_accepts", 64'(n), 64'(DEPTH - 1));
    check("stall_in_ready", 64'(last_in_ready), 64'd0);
    drain();

    // Clear in the middle of a run with a non-empty FIFO
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (4) send(16'h1234, 1'b0, tries);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("busy_before_clear", 64'(busy), 64'd1);
    check("valid_before_clear", 64'(bus.out_valid), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("clear_out_valid", 64'(bus.out_valid), 64'd0);
    check("clear_busy", 64'(busy), 64'd0);
    send(16'h4321, 1'b1, tries);
    drain();

    // Randomized traffic
    cur = 16'h0100;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) < 3) cur = 16'h0100 + W'($urandom_range(0, 2));
      rc = ($urandom_range(0, 499) == 0);
      rf = !rc && ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 9) < 8, cur, rf, rc, $urandom_range(0, 9) < 7);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("final_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
